uart_tx_arbiter: RTL

- Shares one uart_tx serializer between N_REQ byte-stream requesters.
- Grants are round-robin, at packet granularity: a grant is held until the requester's byte flagged "last" has been fully shifted out.
- Sequences the serializer: drives o_Tx_DV/o_Tx_Byte and tracks i_Tx_Active/i_Tx_Done, so the serializer is never loaded while busy.
- Aborts a packet whose requester stalls mid-packet longer than GAP_TIMEOUT.

---
 rtl/uart_tx_arbiter.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one uart_tx serializer between N_REQ byte-stream
// requesters. Grants are round-robin and held for a whole packet, that is until
// the byte flagged "last" has been shifted out. A packet whose requester stalls
// mid-packet for GAP_TIMEOUT cycles is aborted.
//
// Optional feature: define UART_ARB_ID_HEADER_EN to send one header byte
// {4'hA, 1'b0, g[2:0]} ahead of each granted packet.
//
// Ports:
//   i_Clock, i_Reset_n        clock, asynchronous active-low reset
//   i_Req_Valid/Byte/Last     per-requester byte stream (byte k at [8k+7:8k])
//   o_Req_Ready               combinational one-hot accept strobe (LOAD only)
//   o_Grant                   registered one-hot owner, 0 when idle
//   o_Abort                   one-cycle pulse on a timed-out requester
//   o_Tx_DV, o_Tx_Byte        load strobe and byte to uart_tx
//   i_Tx_Active, i_Tx_Done    uart_tx status
module uart_tx_arbiter #(
  parameter int unsigned N_REQ       = 4,
  parameter int unsigned GAP_TIMEOUT = 1024
) (
  input  logic                 i_Clock,
  input  logic                 i_Reset_n,
  input  logic [N_REQ-1:0]     i_Req_Valid,
  input  logic [8*N_REQ-1:0]   i_Req_Byte,
  input  logic [N_REQ-1:0]     i_Req_Last,
  output logic [N_REQ-1:0]     o_Req_Ready,
  output logic [N_REQ-1:0]     o_Grant,
  output logic [N_REQ-1:0]     o_Abort,
  output logic                 o_Tx_DV,
  output logic [7:0]           o_Tx_Byte,
  input  logic                 i_Tx_Active,
  input  logic                 i_Tx_Done
);

  localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned GAP_W = $clog2(GAP_TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT_DONE
`ifdef UART_ARB_ID_HEADER_EN
    , S_HEADER
`endif
  } state_t;

  state_t             state_q, state_d;
  logic [N_REQ-1:0]   grant_q, grant_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [IDX_W-1:0]   last_grant_q, last_grant_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic               last_flag_q, last_flag_d;
  logic [N_REQ-1:0]   abort_q, abort_d;
  logic               dv_q, dv_d;
  logic [7:0]         byte_q, byte_d;
  logic               done_q;
  logic               done_rise_q;
  logic [N_REQ-1:0]   ready_c;

  logic               sel_found;
  logic [IDX_W-1:0]   sel_idx;
  logic [IDX_W-1:0]   cand;

  // Round-robin search starting just after the previous owner.
  always_comb begin : rr_select
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      cand = IDX_W'((int'(last_grant_q) + i + 1) % int'(N_REQ));
      if (!sel_found && i_Req_Valid[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  // Next-state and registered-output logic.
  always_comb begin : fsm_next
    state_d      = state_q;
    grant_d      = grant_q;
    idx_d        = idx_q;
    last_grant_d = last_grant_q;
    gap_d        = gap_q;
    last_flag_d  = last_flag_q;
    abort_d      = '0;
    dv_d         = 1'b0;
    byte_d       = byte_q;
    ready_c      = '0;

    case (state_q)
      S_IDLE: begin
        // Also covers a frame left in flight by a reset: wait for Active low.
        if (sel_found && !i_Tx_Active) begin
          grant_d = N_REQ'(1) << sel_idx;
          idx_d   = sel_idx;
          gap_d   = '0;
`ifdef UART_ARB_ID_HEADER_EN
          state_d = S_HEADER;
`else
          state_d = S_LOAD;
`endif
        end
      end

`ifdef UART_ARB_ID_HEADER_EN
      // Header is never the packet end, so WAIT_DONE returns to LOAD.
      S_HEADER: begin
        byte_d      = {4'hA, 1'b0, 3'(idx_q)};
        last_flag_d = 1'b0;
        dv_d        = 1'b1;
        state_d     = S_WAIT_DONE;
      end
`endif

      S_LOAD: begin
        if (i_Req_Valid[idx_q]) begin
          ready_c[idx_q] = 1'b1;
          byte_d         = i_Req_Byte[{idx_q, 3'b000} +: 8];
          last_flag_d    = i_Req_Last[idx_q];
          gap_d          = '0;
          dv_d           = 1'b1;
          state_d        = S_WAIT_DONE;
        end else if (gap_q == GAP_W'(GAP_TIMEOUT - 1)) begin
          // Stalled for GAP_TIMEOUT cycles: drop the packet.
          abort_d[idx_q] = 1'b1;
          grant_d        = '0;
          last_grant_d   = idx_q;
          gap_d          = '0;
          state_d        = S_IDLE;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end

      S_WAIT_DONE: begin
        if (done_rise_q) begin
          if (last_flag_q) begin
            grant_d      = '0;
            last_grant_d = idx_q;
            state_d      = S_IDLE;
          end else begin
            state_d = S_LOAD;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; Done edge detect runs continuously so a
  // level already high on entry to WAIT_DONE is never taken as a new edge.
  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state_q      <= S_IDLE;
      grant_q      <= '0;
      idx_q        <= '0;
      last_grant_q <= IDX_W'(N_REQ - 1);
      gap_q        <= '0;
      last_flag_q  <= 1'b0;
      abort_q      <= '0;
      dv_q         <= 1'b0;
      byte_q       <= 8'h00;
      done_q       <= 1'b0;
      done_rise_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      idx_q        <= idx_d;
      last_grant_q <= last_grant_d;
      gap_q        <= gap_d;
      last_flag_q  <= last_flag_d;
      abort_q      <= abort_d;
      dv_q         <= dv_d;
      byte_q       <= byte_d;
      done_q       <= i_Tx_Done;
      done_rise_q  <= i_Tx_Done & ~done_q;
    end
  end

  assign o_Req_Ready = ready_c;
  assign o_Grant     = grant_q;
  assign o_Abort     = abort_q;
  assign o_Tx_DV     = dv_q;
  assign o_Tx_Byte   = byte_q;

endmodule
